// File: rtl/dice_rf_pkg.sv
// ============================================================================
// dice_rf_pkg: types and the bank-address helper shared by the DICE RF read
// (dispatch) and write (writeback) address paths.
// Rev 1.0
// ============================================================================
`default_nettype none

package dice_rf_pkg;

  localparam int RF_NUM_BANK = 16;
  localparam int RF_ADDR_W   = 9;
  localparam int RF_DATA_W   = 32;

  // Writeback packet at the default bank geometry
  typedef struct packed {
    logic [RF_ADDR_W-1:0]             tid;
    logic [RF_NUM_BANK-1:0]           mask;
    logic [RF_NUM_BANK*RF_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RETRY = 2'd2
  } wb_state_t;

  // Per-bit select between override value and thread id; operands are
  // zero-extended to 32 bits so any bank address width up to 32 can share it.
  function automatic logic [31:0] rf_bank_addr(input logic [31:0] tid,
                                               input logic [31:0] ovr_en,
                                               input logic [31:0] ovr_addr);
    return (ovr_en & ovr_addr) | (~ovr_en & tid);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dice_rf_wb_fifo.sv
// ============================================================================
// dice_rf_wb_fifo: synchronous FIFO with async-reset pointers and count.
// DEPTH must be a power of two (>=2); pointers wrap naturally.
// Rev 1.0
// ============================================================================
`default_nettype none

module dice_rf_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dice_rf_writeback_unit.sv
// ============================================================================
// dice_rf_writeback_unit: buffers per-thread result packets and issues
// per-bank RF writes, retrying stalled banks. Optional perf counters are
// built when DICE_RF_WB_PERF_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module dice_rf_writeback_unit
  import dice_rf_pkg::*;
#(
  parameter int NUM_BANK   = 16,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wb_valid,
  output logic                           wb_ready,
  input  logic [ADDR_WIDTH-1:0]          wb_tid,
  input  logic [NUM_BANK-1:0]            wb_bank_mask,
  input  logic [NUM_BANK*DATA_WIDTH-1:0] wb_data,
  input  logic [NUM_BANK*ADDR_WIDTH-1:0] override_enable,
  input  logic [NUM_BANK*ADDR_WIDTH-1:0] override_address,
  input  logic [NUM_BANK-1:0]            rf_wr_stall,
  output logic [NUM_BANK-1:0]            rf_wr_en,
  output logic [NUM_BANK*ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [NUM_BANK*DATA_WIDTH-1:0] rf_wr_data,
  output logic                           idle,
  output logic [31:0]                    perf_stall_cycles,
  output logic [31:0]                    perf_packets
);

  localparam int DW_ALL  = NUM_BANK * DATA_WIDTH;
  localparam int ENTRY_W = ADDR_WIDTH + NUM_BANK + DW_ALL;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  wb_state_t                     r_state;
  wb_state_t                     w_next_state;
  logic [NUM_BANK-1:0]           r_remaining;
  logic [NUM_BANK-1:0]           r_wr_en;
  logic [NUM_BANK*ADDR_WIDTH-1:0] r_wr_addr;
  logic [DW_ALL-1:0]             r_wr_data;

  logic                          w_push;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_empty;
  logic [CNT_W-1:0]              w_count;
  logic [ENTRY_W-1:0]            w_head;
  logic [ADDR_WIDTH-1:0]         w_head_tid;
  logic [NUM_BANK-1:0]           w_head_mask;
  logic [DW_ALL-1:0]             w_head_data;
  logic                          w_active;
  logic                          w_more;
  logic [NUM_BANK-1:0]           w_rem;
  logic [NUM_BANK-1:0]           w_write;
  logic [NUM_BANK-1:0]           w_left;
  logic [NUM_BANK*ADDR_WIDTH-1:0] w_bank_addr;

  assign w_push   = wb_valid && wb_ready;
  assign wb_ready = !w_full;

  // Entry layout mirrors wb_entry_t: {tid, mask, data}
  dice_rf_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({wb_tid, wb_bank_mask, wb_data}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_tid, w_head_mask, w_head_data} = w_head;

  always_comb begin
    w_bank_addr = '0;
    for (int i = 0; i < NUM_BANK; i++) begin
      w_bank_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(rf_bank_addr(
          32'(w_head_tid),
          32'(override_enable[i*ADDR_WIDTH +: ADDR_WIDTH]),
          32'(override_address[i*ADDR_WIDTH +: ADDR_WIDTH])));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // A fresh head (ISSUE) uses its stored mask; a retried head uses what is left.
  always_comb begin
    w_active = (r_state != ST_IDLE);
    w_rem    = '0;
    case (r_state)
      ST_ISSUE: w_rem = w_head_mask;
      ST_RETRY: w_rem = r_remaining;
      default:  w_rem = '0;
    endcase
    w_write = w_rem & ~rf_wr_stall;
    w_left  = w_rem & rf_wr_stall;
    w_pop   = w_active && (w_left == '0);
    w_more  = (w_count > CNT_W'(1)) || w_push;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push || !w_empty) w_next_state = ST_ISSUE;
      end
      ST_ISSUE, ST_RETRY: begin
        if (w_pop) w_next_state = w_more ? ST_ISSUE : ST_IDLE;
        else       w_next_state = ST_RETRY;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remaining <= '0;
      r_wr_en     <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      if (w_active) r_remaining <= w_left;
      r_wr_en <= w_write;
      for (int i = 0; i < NUM_BANK; i++) begin
        if (w_write[i]) begin
          r_wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] <= w_bank_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_wr_data[i*DATA_WIDTH +: DATA_WIDTH] <= w_head_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;
  assign idle       = (r_state == ST_IDLE) && w_empty && (r_wr_en == '0);

`ifdef DICE_RF_WB_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_pkts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_pkts  <= '0;
    end else begin
      if (w_active && (w_left != '0) && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + 32'd1;
      if (w_pop && (r_perf_pkts != '1))
        r_perf_pkts <= r_perf_pkts + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_packets      = r_perf_pkts;
`else
  assign perf_stall_cycles = '0;
  assign perf_packets      = '0;
`endif

endmodule

`default_nettype wire
